// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RISC-V control path: FSM states, opcodes
// and the select/operation codes driven onto the datapath.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    s_fetch,
    s_decode,
    s_memadr,
    s_memread,
    s_memwb,
    s_memwrite,
    s_executer,
    s_executei,
    s_aluwb,
    s_jal,
    s_jalr1,
    s_jalr2,
    s_branch,
    s_lui
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] RES_IMMEXT    = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REGA  = 2'b10;

  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  // Immediate format depends only on the opcode; illegal opcodes fall back to I.
  function automatic logic [2:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_LW, OP_I, OP_JALR: imm_src_of = IMM_I;
      OP_SW:                imm_src_of = IMM_S;
      OP_BRANCH:            imm_src_of = IMM_B;
      OP_JAL:               imm_src_of = IMM_J;
      OP_LUI:               imm_src_of = IMM_U;
      default:              imm_src_of = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation decode; shared with the single-cycle control path.
// opb5 separates R-type (sub allowed) from I-type ALU ops (always add on funct3 000).
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       opb5,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alucontrol = (opb5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b111:  alucontrol = ALU_AND;
          3'b110:  alucontrol = ALU_OR;
          3'b010:  alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for a shared-memory, single-ALU multi-cycle RISC-V datapath.
// Only PCWrite looks at the current-cycle branch condition.
module multicycle_controller
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       zero,
  input  logic       lt,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       RegWrite
);

  state_t     state, next_state;
  logic [1:0] aluop;
  logic       pcupdate;
  logic       branch;
  logic       taken;
  logic       unused_funct7;

  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  always_ff @(posedge clk) begin
    if (rst) state <= s_fetch;
    else     state <= next_state;
  end

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      3'b100:  taken = lt;
      3'b101:  taken = !lt;
      default: taken = 1'b0;
    endcase
  end

  assign ImmSrc = imm_src_of(opcode);

  always_comb begin
    next_state = s_fetch;
    pcupdate   = 1'b0;
    branch     = 1'b0;
    aluop      = ALUOP_ADD;
    IRWrite    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_REGB;
    case (state)
      s_fetch: begin
        IRWrite    = 1'b1;
        ALUSrcB    = SRCB_FOUR;
        ResultSrc  = RES_ALURESULT;
        pcupdate   = 1'b1;
        next_state = s_decode;
      end
      s_decode: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (opcode)
          OP_LW, OP_SW: next_state = s_memadr;
          OP_R:         next_state = s_executer;
          OP_I:         next_state = s_executei;
          OP_JAL:       next_state = s_jal;
          OP_JALR:      next_state = s_jalr1;
          OP_BRANCH:    next_state = s_branch;
          OP_LUI:       next_state = s_lui;
          default:      next_state = s_fetch;
        endcase
      end
      s_memadr: begin
        ALUSrcA    = SRCA_REGA;
        ALUSrcB    = SRCB_IMM;
        next_state = (opcode == OP_LW) ? s_memread : s_memwrite;
      end
      s_memread: begin
        AdrSrc     = 1'b1;
        next_state = s_memwb;
      end
      s_memwb: begin
        ResultSrc  = RES_DATA;
        RegWrite   = 1'b1;
        next_state = s_fetch;
      end
      s_memwrite: begin
        AdrSrc     = 1'b1;
        MemWrite   = 1'b1;
        next_state = s_fetch;
      end
      s_executer: begin
        ALUSrcA    = SRCA_REGA;
        aluop      = ALUOP_FUNCT;
        next_state = s_aluwb;
      end
      s_executei: begin
        ALUSrcA    = SRCA_REGA;
        ALUSrcB    = SRCB_IMM;
        aluop      = ALUOP_FUNCT;
        next_state = s_aluwb;
      end
      s_aluwb: begin
        RegWrite   = 1'b1;
        ResultSrc  = RES_ALUOUT;
        next_state = s_fetch;
      end
      s_jal, s_jalr2: begin
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_FOUR;
        pcupdate   = 1'b1;
        next_state = s_aluwb;
      end
      s_jalr1: begin
        ALUSrcA    = SRCA_REGA;
        ALUSrcB    = SRCB_IMM;
        next_state = s_jalr2;
      end
      s_branch: begin
        ALUSrcA    = SRCA_REGA;
        aluop      = ALUOP_SUB;
        branch     = 1'b1;
        next_state = s_fetch;
      end
      s_lui: begin
        ResultSrc  = RES_IMMEXT;
        RegWrite   = 1'b1;
        next_state = s_fetch;
      end
      default: next_state = s_fetch;
    endcase

    PCWrite = pcupdate | (branch & taken);

    // Reset silences every write and parks the selects at their fetch values.
    if (rst) begin
      PCWrite   = 1'b0;
      IRWrite   = 1'b0;
      MemWrite  = 1'b0;
      RegWrite  = 1'b0;
      AdrSrc    = 1'b0;
      ALUSrcA   = SRCA_PC;
      ALUSrcB   = SRCB_FOUR;
      ResultSrc = RES_ALURESULT;
      aluop     = ALUOP_ADD;
    end
  end

  alu_decoder u_alu_decoder (
    .aluop      (aluop),
    .funct3     (funct3),
    .funct7b5   (funct7[5]),
    .opb5       (opcode[5]),
    .alucontrol (ALUControl)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed cycle-by-cycle check of the multi-cycle control FSM outputs.
// Inputs change 1ns after posedge; outputs are compared on the falling edge.
module tb_multicycle_controller;

  logic       clk;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       zero;
  logic       lt;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ImmSrc, ALUControl;

  int checks = 0;
  int errors = 0;

  multicycle_controller dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .funct3     (funct3),
    .funct7     (funct7),
    .zero       (zero),
    .lt         (lt),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl),
    .RegWrite   (RegWrite)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3,
                               input logic [6:0] f7, input logic z, input logic l);
    opcode = op;
    funct3 = f3;
    funct7 = f7;
    zero   = z;
    lt     = l;
  endtask

  // Compares the full output bundle for one cycle, then advances to the next cycle.
  task automatic checkOutput(input string tag, input logic pcw, input logic adr,
                             input logic mw, input logic irw, input logic [1:0] res,
                             input logic [1:0] srca, input logic [1:0] srcb,
                             input logic [2:0] imm, input logic [2:0] aluc,
                             input logic rw);
    logic [16:0] observed, expected;
    @(negedge clk);
    observed = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                ImmSrc, ALUControl, RegWrite};
    expected = {pcw, adr, mw, irw, res, srca, srcb, imm, aluc, rw};
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fetchCycle(input string tag, input logic [2:0] imm);
    checkOutput(tag, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, imm, 3'b000, 0);
  endtask

  task automatic decodeCycle(input string tag, input logic [2:0] imm);
    checkOutput(tag, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 3'b000, 0);
  endtask

  task automatic resetCycle(input string tag, input logic [2:0] imm);
    checkOutput(tag, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, imm, 3'b000, 0);
  endtask

  task automatic aluwbCycle(input string tag, input logic [2:0] imm);
    checkOutput(tag, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, imm, 3'b000, 1);
  endtask

  task automatic branchCase(input string tag, input logic [2:0] f3, input logic z,
                            input logic l, input logic pcw);
    applyStimulus(7'b1100011, f3, 7'b0000000, z, l);
    fetchCycle({tag, "_fetch"}, 3'b010);
    decodeCycle({tag, "_decode"}, 3'b010);
    checkOutput({tag, "_branch"}, pcw, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b010, 3'b001, 0);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(7'b0110011, 3'b000, 7'b0100000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    resetCycle("rst_init0", 3'b000);
    resetCycle("rst_init1", 3'b000);
    rst = 1'b0;

    // sub: R-type with funct7[5] set
    fetchCycle("sub_fetch", 3'b000);
    decodeCycle("sub_decode", 3'b000);
    checkOutput("sub_exec", 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b001, 0);
    aluwbCycle("sub_aluwb", 3'b000);

    // Reset asserted for three cycles inside EXECUTER
    fetchCycle("abort_fetch", 3'b000);
    decodeCycle("abort_decode", 3'b000);
    rst = 1'b1;
    resetCycle("abort_rst0", 3'b000);
    resetCycle("abort_rst1", 3'b000);
    resetCycle("abort_rst2", 3'b000);
    rst = 1'b0;

    // lw
    applyStimulus(7'b0000011, 3'b010, 7'b0000000, 1'b0, 1'b0);
    fetchCycle("lw_fetch", 3'b000);
    decodeCycle("lw_decode", 3'b000);
    checkOutput("lw_memadr", 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0);
    checkOutput("lw_memread", 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0);
    checkOutput("lw_memwb", 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 1);

    // add: R-type with funct7 clear
    applyStimulus(7'b0110011, 3'b000, 7'b0000000, 1'b0, 1'b0);
    fetchCycle("add_fetch", 3'b000);
    decodeCycle("add_decode", 3'b000);
    checkOutput("add_exec", 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b000, 0);
    aluwbCycle("add_aluwb", 3'b000);

    // and: R-type funct3 111
    applyStimulus(7'b0110011, 3'b111, 7'b0000000, 1'b0, 1'b0);
    fetchCycle("and_fetch", 3'b000);
    decodeCycle("and_decode", 3'b000);
    checkOutput("and_exec", 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b010, 0);
    aluwbCycle("and_aluwb", 3'b000);

    // addi with funct7[5] set must still add
    applyStimulus(7'b0010011, 3'b000, 7'b0100000, 1'b0, 1'b0);
    fetchCycle("addi_fetch", 3'b000);
    decodeCycle("addi_decode", 3'b000);
    checkOutput("addi_exec", 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0);
    aluwbCycle("addi_aluwb", 3'b000);

    // slti: funct3 010
    applyStimulus(7'b0010011, 3'b010, 7'b0000000, 1'b0, 1'b0);
    fetchCycle("slti_fetch", 3'b000);
    decodeCycle("slti_decode", 3'b000);
    checkOutput("slti_exec", 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b101, 0);
    aluwbCycle("slti_aluwb", 3'b000);

    // sw
    applyStimulus(7'b0100011, 3'b010, 7'b0000000, 1'b0, 1'b0);
    fetchCycle("sw_fetch", 3'b001);
    decodeCycle("sw_decode", 3'b001);
    checkOutput("sw_memadr", 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b001, 3'b000, 0);
    checkOutput("sw_memwrite", 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b001, 3'b000, 0);

    // Branches: taken decision per funct3 and flag
    branchCase("beq_z1", 3'b000, 1'b1, 1'b0, 1'b1);
    branchCase("beq_z0", 3'b000, 1'b0, 1'b0, 1'b0);
    branchCase("bne_z0", 3'b001, 1'b0, 1'b0, 1'b1);
    branchCase("blt_l1", 3'b100, 1'b0, 1'b1, 1'b1);
    branchCase("bge_l1", 3'b101, 1'b0, 1'b1, 1'b0);
    branchCase("bge_l0", 3'b101, 1'b1, 1'b0, 1'b1);
    branchCase("b010_z1", 3'b010, 1'b1, 1'b1, 1'b0);

    // jalr
    applyStimulus(7'b1100111, 3'b000, 7'b0000000, 1'b0, 1'b0);
    fetchCycle("jalr_fetch", 3'b000);
    decodeCycle("jalr_decode", 3'b000);
    checkOutput("jalr_1", 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0);
    checkOutput("jalr_2", 1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 3'b000, 0);
    aluwbCycle("jalr_aluwb", 3'b000);

    // jal
    applyStimulus(7'b1101111, 3'b000, 7'b0000000, 1'b0, 1'b0);
    fetchCycle("jal_fetch", 3'b011);
    decodeCycle("jal_decode", 3'b011);
    checkOutput("jal_jal", 1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b011, 3'b000, 0);
    aluwbCycle("jal_aluwb", 3'b011);

    // lui
    applyStimulus(7'b0110111, 3'b000, 7'b0000000, 1'b0, 1'b0);
    fetchCycle("lui_fetch", 3'b100);
    decodeCycle("lui_decode", 3'b100);
    checkOutput("lui_lui", 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 3'b100, 3'b000, 1);

    // Illegal opcode returns straight to fetch
    applyStimulus(7'b1111111, 3'b000, 7'b0000000, 1'b1, 1'b1);
    fetchCycle("ill_fetch", 3'b000);
    decodeCycle("ill_decode", 3'b000);
    fetchCycle("ill_refetch", 3'b000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
